// File: rtl/ifu_fetch.sv
// ifu_fetch
// Instruction fetch unit for the rvseed multi-cycle core. Owns the program
// counter, issues one request/acknowledge read per instruction and hands the
// fetched word to decode through a start/done pulse pair.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   enable                   low blocks new fetch starts (pending triggers kept)
//   wb_done_en               pulse from write-back: fetch the next instruction
//   exu_redirect_en          pulse from execute: branch/jump taken
//   exu_target_pc            redirect target (low two bits ignored)
//   imem_req/imem_addr       instruction memory read request and address
//   imem_ack/imem_rdata      memory acknowledge and instruction word
//   ifu_start_en             one-cycle pulse in the first FETCH cycle
//   ifu_done_en              one-cycle pulse when ifu_inst/ifu_inst_pc are new
//   ifu_inst_pc, ifu_inst    PC and word of the last delivered instruction
//   ifu_busy                 high while a memory access is in flight
module ifu_fetch #(
    parameter int unsigned          CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned          PC_STEP   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 wb_done_en,
    input  logic                 exu_redirect_en,
    input  logic [CPU_WIDTH-1:0] exu_target_pc,
    output logic                 imem_req,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [CPU_WIDTH-1:0] imem_rdata,
    output logic                 ifu_start_en,
    output logic                 ifu_done_en,
    output logic [CPU_WIDTH-1:0] ifu_inst_pc,
    output logic [CPU_WIDTH-1:0] ifu_inst,
    output logic                 ifu_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CPU_WIDTH-1:0] pc_q, pc_d;
    logic [CPU_WIDTH-1:0] tgt_q, tgt_d;
    logic [CPU_WIDTH-1:0] inst_q, inst_d;
    logic [CPU_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                 first_pend_q, first_pend_d;
    logic                 redir_pend_q, redir_pend_d;
    logic                 next_pend_q, next_pend_d;
    logic                 start_q, start_d;
    logic                 done_q, done_d;

    logic [CPU_WIDTH-1:0] target_aligned;
    logic [CPU_WIDTH-1:0] pc_next;
    logic                 fetch_trigger;

    // Instructions are word aligned, so the target's byte offset is dropped.
    assign target_aligned = {exu_target_pc[CPU_WIDTH-1:2], 2'b00};
    assign pc_next        = pc_q + CPU_WIDTH'(PC_STEP);

    // A redirect arriving in this very cycle does not count here: in IDLE it
    // has already been folded into pc_d, so whatever else triggers the fetch
    // starts from the target, and on its own it starts one cycle later.
    assign fetch_trigger  = enable & (first_pend_q | wb_done_en | redir_pend_q | next_pend_q);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        first_pend_d = first_pend_q;
        redir_pend_d = redir_pend_q;
        next_pend_d  = next_pend_q;
        start_d      = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (exu_redirect_en) begin
                    pc_d         = target_aligned;
                    redir_pend_d = 1'b1;
                end
                if (wb_done_en) begin
                    next_pend_d = 1'b1;
                end
                // Every pending reason is satisfied by this single fetch.
                if (fetch_trigger) begin
                    state_d      = FETCH;
                    start_d      = 1'b1;
                    first_pend_d = 1'b0;
                    redir_pend_d = 1'b0;
                    next_pend_d  = 1'b0;
                end
            end

            FETCH: begin
                if (wb_done_en) begin
                    next_pend_d = 1'b1;
                end
                // pc_q must stay put while the request is outstanding, so a
                // redirect here parks its target in tgt_q until the ack.
                if (exu_redirect_en) begin
                    tgt_d        = target_aligned;
                    redir_pend_d = 1'b1;
                end
                if (imem_ack) begin
                    state_d = IDLE;
                    if (exu_redirect_en) begin
                        pc_d = target_aligned;
                    end else if (redir_pend_q) begin
                        pc_d = tgt_q;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        done_d    = 1'b1;
                        pc_d      = pc_next;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            tgt_q        <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            first_pend_q <= 1'b1;
            redir_pend_q <= 1'b0;
            next_pend_q  <= 1'b0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            first_pend_q <= first_pend_d;
            redir_pend_q <= redir_pend_d;
            next_pend_q  <= next_pend_d;
            start_q      <= start_d;
            done_q       <= done_d;
        end
    end

    // Request comes straight from the state flop so an async reset drops it
    // immediately; the address is zeroed whenever no request is outstanding.
    assign imem_req     = (state_q == FETCH);
    assign imem_addr    = (state_q == FETCH) ? pc_q : '0;
    assign ifu_busy     = (state_q == FETCH);
    assign ifu_start_en = start_q;
    assign ifu_done_en  = done_q;
    assign ifu_inst     = inst_q;
    assign ifu_inst_pc  = inst_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch
// Directed and randomized checks of ifu_fetch against a transaction-level
// model: each delivered instruction sits at the previous PC plus four, or at
// the word-aligned redirect target, and carries the memory word at that PC.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        wb_done_en;
    logic        exu_redirect_en;
    logic [31:0] exu_target_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ifu_start_en;
    logic        ifu_done_en;
    logic [31:0] ifu_inst_pc;
    logic [31:0] ifu_inst;
    logic        ifu_busy;

    int          testsRun    = 0;
    int          testsFailed = 0;
    int          memLat      = 1;
    int          reqAge      = 0;
    logic        prevReq     = 1'b0;
    logic [31:0] heldAddr    = '0;
    logic [31:0] modelPc     = '0;

    ifu_fetch #(
        .CPU_WIDTH(32),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .wb_done_en     (wb_done_en),
        .exu_redirect_en(exu_redirect_en),
        .exu_target_pc  (exu_target_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .ifu_start_en   (ifu_start_en),
        .ifu_done_en    (ifu_done_en),
        .ifu_inst_pc    (ifu_inst_pc),
        .ifu_inst       (ifu_inst),
        .ifu_busy       (ifu_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents; address 0 holds addi x1,x0,5.
    function automatic logic [31:0] instMem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs; the pulses are cleared at the next negedge.
    task automatic applyStimulus(input logic en, input logic wb, input logic red,
                                 input logic [31:0] tgt);
        enable          = en;
        wb_done_en      = wb;
        exu_redirect_en = red;
        exu_target_pc   = tgt;
        @(negedge clk);
        wb_done_en      = 1'b0;
        exu_redirect_en = 1'b0;
    endtask

    task automatic waitDone(output logic [31:0] pc, output logic [31:0] inst);
        logic found;
        found = 1'b0;
        pc    = '0;
        inst  = '0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ifu_done_en) begin
                found = 1'b1;
                pc    = ifu_inst_pc;
                inst  = ifu_inst;
            end
        end
        checkOutput("done_seen", 32'(found), 32'd1);
    endtask

    task automatic waitStart(output logic [31:0] addr, output logic sawDone);
        logic found;
        found   = 1'b0;
        sawDone = 1'b0;
        addr    = '0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ifu_done_en) sawDone = 1'b1;
            if (ifu_start_en) begin
                found = 1'b1;
                addr  = imem_addr;
            end
        end
        checkOutput("start_seen", 32'(found), 32'd1);
    endtask

    // Wait for the next delivery and compare it with the model PC.
    task automatic expectDelivery(input string tag, input logic [31:0] pcExp);
        logic [31:0] pc;
        logic [31:0] inst;
        waitDone(pc, inst);
        checkOutput({tag, "_pc"}, pc, pcExp);
        checkOutput({tag, "_inst"}, inst, instMem(pcExp));
    endtask

    // Memory responder: ack after memLat cycles of request, word from instMem.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst || !imem_req) begin
                imem_ack = 1'b0;
                reqAge   = 0;
            end else begin
                imem_ack   = (reqAge == memLat);
                imem_rdata = instMem(imem_addr);
                reqAge++;
            end
        end
    end

    // Address must not move while a request is outstanding.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && imem_req && prevReq) checkOutput("addr_stable", imem_addr, heldAddr);
            prevReq  = imem_req && !rst;
            heldAddr = imem_addr;
        end
    end

    initial begin
        logic [31:0] addr;
        logic [31:0] tgt;
        logic        sawDone;
        int          kind;
        int          gap;

        rst             = 1'b1;
        enable          = 1'b0;
        wb_done_en      = 1'b0;
        exu_redirect_en = 1'b0;
        exu_target_pc   = '0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_start", 32'(ifu_start_en), 32'd0);
        checkOutput("rst_done", 32'(ifu_done_en), 32'd0);
        checkOutput("rst_inst", ifu_inst, 32'h0);
        checkOutput("rst_inst_pc", ifu_inst_pc, 32'h0);
        checkOutput("rst_busy", 32'(ifu_busy), 32'd0);

        // First fetch after reset release, memory acks one cycle after req
        memLat = 1;
        enable = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        checkOutput("first_start_c1", 32'(ifu_start_en), 32'd1);
        checkOutput("first_req_c1", 32'(imem_req), 32'd1);
        checkOutput("first_addr_c1", imem_addr, 32'h0);
        checkOutput("first_busy_c1", 32'(ifu_busy), 32'd1);
        @(negedge clk);
        checkOutput("first_start_c2", 32'(ifu_start_en), 32'd0);
        checkOutput("first_done_c2", 32'(ifu_done_en), 32'd0);
        @(negedge clk);
        checkOutput("first_done_c3", 32'(ifu_done_en), 32'd1);
        checkOutput("first_pc_c3", ifu_inst_pc, 32'h0);
        checkOutput("first_inst_c3", ifu_inst, 32'h0050_0093);
        checkOutput("first_req_c3", 32'(imem_req), 32'd0);
        @(negedge clk);
        checkOutput("first_done_c4", 32'(ifu_done_en), 32'd0);
        modelPc = 32'h4;

        // Three sequential fetches with slow memory
        memLat = 3;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput("seq_start", 32'(ifu_start_en), 32'd1);
            checkOutput("seq_addr", imem_addr, modelPc);
            expectDelivery("seq", modelPc);
            modelPc = modelPc + 32'h4;
        end

        // Redirect together with wb_done_en: a single fetch from the target
        memLat = 1;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        checkOutput("redir_wb_start", 32'(ifu_start_en), 32'd1);
        checkOutput("redir_wb_addr", imem_addr, 32'h0000_0100);
        expectDelivery("redir_wb", 32'h0000_0100);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("redir_wb_single", 32'(imem_req), 32'd0);
        end

        // Redirect during an in-flight fetch of 0x10: that fetch is discarded
        memLat = 3;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0010);
        @(negedge clk);
        checkOutput("redir_fetch_start", 32'(ifu_start_en), 32'd1);
        checkOutput("redir_fetch_addr", imem_addr, 32'h0000_0010);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0200);
        waitStart(addr, sawDone);
        checkOutput("redir_fetch_no_done", 32'(sawDone), 32'd0);
        checkOutput("redir_fetch_new_addr", addr, 32'h0000_0200);
        checkOutput("redir_fetch_inst_held", ifu_inst, instMem(32'h0000_0100));
        checkOutput("redir_fetch_pc_held", ifu_inst_pc, 32'h0000_0100);
        expectDelivery("redir_fetch", 32'h0000_0200);
        modelPc = 32'h0000_0204;

        // wb_done_en while disabled stays pending until enable returns
        memLat = 2;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("disabled_no_req", 32'(imem_req), 32'd0);
            @(negedge clk);
        end
        enable = 1'b1;
        @(negedge clk);
        checkOutput("enable_start", 32'(ifu_start_en), 32'd1);
        checkOutput("enable_addr", imem_addr, modelPc);
        expectDelivery("enable", modelPc);

        // PC wrap at the top of the address space, then reset mid-fetch
        memLat = 1;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        checkOutput("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
        expectDelivery("wrap_top", 32'hFFFF_FFFC);
        memLat = 3;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("wrap_start", 32'(ifu_start_en), 32'd1);
        checkOutput("wrap_addr", imem_addr, 32'h0);
        checkOutput("wrap_req", 32'(imem_req), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_req", 32'(imem_req), 32'd0);
        checkOutput("rst_mid_busy", 32'(ifu_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_restart", 32'(ifu_start_en), 32'd1);
        checkOutput("rst_mid_addr", imem_addr, 32'h0);
        expectDelivery("rst_mid", 32'h0);
        modelPc = 32'h4;

        // Randomized mix of sequential, redirected, disabled and killed fetches
        for (int n = 0; n < 40; n++) begin
            kind   = int'($urandom_range(0, 3));
            memLat = int'($urandom_range(0, 3));
            tgt    = $urandom();
            case (kind)
                0: begin
                    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
                    checkOutput("rnd_seq_addr", imem_addr, modelPc);
                end
                1: begin
                    applyStimulus(1'b1, 1'b1, 1'b1, tgt);
                    modelPc = {tgt[31:2], 2'b00};
                    checkOutput("rnd_redir_addr", imem_addr, modelPc);
                end
                2: begin
                    gap = int'($urandom_range(1, 4));
                    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
                    for (int k = 0; k < gap; k++) begin
                        checkOutput("rnd_dis_no_req", 32'(imem_req), 32'd0);
                        @(negedge clk);
                    end
                    enable = 1'b1;
                    @(negedge clk);
                    checkOutput("rnd_dis_start", 32'(ifu_start_en), 32'd1);
                    checkOutput("rnd_dis_addr", imem_addr, modelPc);
                end
                default: begin
                    memLat = 3;
                    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
                    checkOutput("rnd_kill_addr", imem_addr, modelPc);
                    applyStimulus(1'b1, 1'b0, 1'b1, tgt);
                    modelPc = {tgt[31:2], 2'b00};
                end
            endcase
            expectDelivery("rnd", modelPc);
            modelPc = modelPc + 32'h4;
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit for the rvseed multi-cycle core. Drives the fetch-to-decode interface that the decode stage consumes: ifu_start_en, ifu_done_en, ifu_inst_pc and ifu_inst. It owns the program counter and issues one request/acknowledge read per instruction to instruction memory. It accepts a branch/jump redirect from the execute stage and a next-instruction trigger from write-back.

Parameters:
CPU_WIDTH, 32, data, instruction and PC width
RESET_PC, 32'h0000_0000, PC value loaded at reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  core clock
rst  input  1  asynchronous reset, active-high
enable  input  1  rvseed enable; low blocks new fetch starts
wb_done_en  input  1  one-cycle pulse: previous instruction retired, fetch next
exu_redirect_en  input  1  one-cycle pulse: branch/jump taken
exu_target_pc  input  CPU_WIDTH  redirect target PC
imem_req  output  1  instruction memory read request
imem_addr  output  CPU_WIDTH  instruction memory read address
imem_ack  input  1  memory read acknowledge, rdata valid this cycle
imem_rdata  input  CPU_WIDTH  instruction word
ifu_start_en  output  1  one-cycle pulse: fetch started
ifu_done_en  output  1  one-cycle pulse: ifu_inst/ifu_inst_pc valid
ifu_inst_pc  output  CPU_WIDTH  PC of fetched instruction
ifu_inst  output  CPU_WIDTH  fetched instruction word
ifu_busy  output  1  high while in FETCH

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, pc=RESET_PC, first_pend=1, redir_pend=0.
  - All outputs 0.
- State IDLE:
  - A fetch is triggered when enable=1 and (first_pend | wb_done_en | redir_pend).
  - On trigger, move to FETCH next cycle and pulse ifu_start_en for exactly one cycle: the cycle FETCH is entered.
  - Clear first_pend on trigger.
  - When enable=0, the trigger is held pending and no transition occurs:
    - wb_done_en is latched into next_pend.
    - first_pend and redir_pend persist.
- State FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - imem_req drops the cycle after ack; the state returns to IDLE the cycle after ack.
  - On ack with no redirect pending:
    - ifu_inst<=imem_rdata and ifu_inst_pc<=pc.
    - ifu_done_en pulses the next cycle.
    - pc<=pc+PC_STEP, modulo 2^CPU_WIDTH (FFFF_FFFC wraps to 0000_0000).
  - ifu_inst/ifu_inst_pc hold their values until the next ifu_done_en.
- Latency:
  - Trigger at cycle N gives ifu_start_en and imem_req at N+1.
  - Ack at cycle M (M>=N+1) gives ifu_done_en at M+1.
  - Zero-wait memory (ack at N+1) gives done at N+2.
- Redirect:
  - In IDLE, exu_redirect_en loads pc<=exu_target_pc with bits[1:0] forced to 0 and sets redir_pend.
  - Redirect in the same cycle as wb_done_en: the target wins and a single fetch starts from the target.
  - Redirect during FETCH: the target is latched and redir_pend is set. The in-flight access completes, its data is discarded (no ifu_done_en, ifu_inst unchanged), then a new fetch starts from the target.
  - A second redirect before consumption overwrites the target (last wins).
- wb_done_en during FETCH: latched into next_pend and serviced on return to IDLE. Does not abort the access.
- enable falling during FETCH: the access completes normally including ifu_done_en; no further starts.
- Reset mid-FETCH: imem_req drops immediately (async) and pc returns to RESET_PC. Memory must tolerate an abandoned request.
- ifu_busy = (state==FETCH).

Test Plan:
- Reset release, enable=1, ack 1 cycle after req:
  - imem_addr=0x0, ifu_start_en at cycle 1, ifu_done_en at cycle 3.
  - ifu_inst_pc=0x0, ifu_inst=rdata (0x00500093).
- Three wb_done_en pulses with 3-cycle memory latency:
  - addresses 0x4, 0x8, 0xC.
  - imem_addr stable while req high, one done pulse per fetch.
- exu_redirect_en with target=0x103 together with wb_done_en:
  - single fetch at imem_addr=0x100, ifu_inst_pc=0x100.
- Redirect to 0x200 during a 4-cycle fetch of 0x10:
  - no ifu_done_en for 0x10.
  - next req at 0x200, done with ifu_inst_pc=0x200.
- enable=0 when wb_done_en pulses:
  - no req while disabled.
  - enable=1 five cycles later gives ifu_start_en next cycle at the pending PC.
- pc preloaded to 0xFFFF_FFFC via redirect, fetch and wb_done_en:
  - next imem_addr=0x0000_0000.
  - rst asserted mid-fetch forces imem_req=0 the same cycle.
